// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and refill FSM states for the instruction-side refill master.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE,
      ST_ERR
   } refill_state_t;

   function automatic logic [2:0] burst_code(input int beats, input logic wrap);
      logic [2:0] code;
      case (beats)
         8:       code = wrap ? HBURST_WRAP8  : HBURST_INCR8;
         16:      code = wrap ? HBURST_WRAP16 : HBURST_INCR16;
         default: code = wrap ? HBURST_WRAP4  : HBURST_INCR4;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Cache-line assembly register: one 32-bit word written per captured beat, cleared per refill.
module refill_line_buffer #(
   parameter int LINE_BITS = 128,
   parameter int IDX_W     = $clog2(LINE_BITS / 32)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [31:0]          wr_data,
   output logic [LINE_BITS-1:0] line
);

   localparam int WORDS = LINE_BITS / 32;

   logic [LINE_BITS-1:0] line_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         line_q <= '0;
      end else if (wr_en) begin
         for (int w = 0; w < WORDS; w++) begin
            if (wr_idx == IDX_W'(w)) line_q[w*32 +: 32] <= wr_data;
         end
      end
   end

   assign line = line_q;

endmodule

// File: rtl/ahb_refill_master.sv
// I-cache line refill over a single AHB-Lite read burst of 32-bit beats.
// CRITICAL_WORD_FIRST_EN: wrapping burst starting at the missed word instead of INCR from word 0.
//
// state | meaning
// IDLE  | waiting for mem_req; latches line base and start word
// ADDR  | address phases in flight (NONSEQ then SEQ); earlier beats captured alongside
// DATA  | all addresses accepted; collecting the last beat, or finishing an ERROR response
// DONE  | one-cycle mem_ready with the assembled line
// ERR   | one-cycle mem_ready with mem_err, line zeroed
module ahb_refill_master
   import ahb_pkg::*;
#(
   parameter int         LINE_BITS = 128,
   parameter logic [3:0] HPROT_VAL = 4'b0010
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_req,
   input  logic [31:0]          mem_addr,
   output logic [LINE_BITS-1:0] mem_data_in,
   output logic                 mem_ready,
   output logic                 mem_err,
   output logic [31:0]          HADDR,
   output logic [1:0]           HTRANS,
   output logic [2:0]           HBURST,
   output logic [2:0]           HSIZE,
   output logic                 HWRITE,
   output logic [3:0]           HPROT,
   input  logic [31:0]          HRDATA,
   input  logic                 HREADY,
   input  logic                 HRESP
);

   localparam int BEATS = LINE_BITS / 32;
   localparam int IDX_W = $clog2(BEATS);
   localparam int CNT_W = IDX_W + 1;
   localparam int OFF_W = $clog2(LINE_BITS / 8);

   refill_state_t         state_q, state_d;
   htrans_t               htrans_q, htrans_d;
   logic [31:0]           haddr_q, haddr_d;
   logic [31:OFF_W]       base_q, base_d;
   logic [IDX_W-1:0]      start_q, start_d;
   logic [CNT_W-1:0]      addr_cnt_q, addr_cnt_d;
   logic [CNT_W-1:0]      data_cnt_q, data_cnt_d;
   logic                  err_q, err_d;
   logic                  mem_ready_q, mem_ready_d;
   logic                  mem_err_q, mem_err_d;
   logic                  buf_clr, buf_we;

   logic [IDX_W-1:0]      req_word, first_word, start_eff;
   logic [IDX_W-1:0]      addr_word, next_word, wr_idx;
   logic                  pending;
   logic                  unused_bits;

   assign req_word = mem_addr[OFF_W-1:2];

`ifdef CRITICAL_WORD_FIRST_EN
   assign first_word  = req_word;
   assign start_eff   = start_q;
   assign HBURST      = burst_code(BEATS, 1'b1);
   assign unused_bits = ^mem_addr[1:0];
`else
   assign first_word  = '0;
   assign start_eff   = '0;
   assign HBURST      = burst_code(BEATS, 1'b0);
   assign unused_bits = ^{mem_addr[1:0], start_q};
`endif

   // Word indices wrap naturally in IDX_W bits, which gives both WRAPn order and placement.
   assign addr_word = start_eff + addr_cnt_q[IDX_W-1:0];
   assign next_word = addr_word + IDX_W'(1);
   assign wr_idx    = start_eff + data_cnt_q[IDX_W-1:0];
   assign pending   = (addr_cnt_q != data_cnt_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         htrans_q    <= HTRANS_IDLE;
         haddr_q     <= '0;
         base_q      <= '0;
         start_q     <= '0;
         addr_cnt_q  <= '0;
         data_cnt_q  <= '0;
         err_q       <= 1'b0;
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         base_q      <= base_d;
         start_q     <= start_d;
         addr_cnt_q  <= addr_cnt_d;
         data_cnt_q  <= data_cnt_d;
         err_q       <= err_d;
         mem_ready_q <= mem_ready_d;
         mem_err_q   <= mem_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      base_d      = base_q;
      start_d     = start_q;
      addr_cnt_d  = addr_cnt_q;
      data_cnt_d  = data_cnt_q;
      err_d       = err_q;
      mem_ready_d = 1'b0;
      mem_err_d   = 1'b0;
      buf_clr     = 1'b0;
      buf_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               base_d     = mem_addr[31:OFF_W];
               start_d    = req_word;
               addr_cnt_d = '0;
               data_cnt_d = '0;
               err_d      = 1'b0;
               buf_clr    = 1'b1;
               htrans_d   = HTRANS_NONSEQ;
               haddr_d    = {mem_addr[31:OFF_W], first_word, 2'b00};
               state_d    = ST_ADDR;
            end
         end

         ST_ADDR: begin
            // First ERROR cycle cancels the address phase currently on the bus.
            if (pending && HRESP && !HREADY) begin
               htrans_d = HTRANS_IDLE;
               err_d    = 1'b1;
               state_d  = ST_DATA;
            end else if (HREADY) begin
               if (pending) begin
                  buf_we     = 1'b1;
                  data_cnt_d = data_cnt_q + CNT_W'(1);
               end
               addr_cnt_d = addr_cnt_q + CNT_W'(1);
               if (addr_cnt_q == CNT_W'(BEATS - 1)) begin
                  htrans_d = HTRANS_IDLE;
                  state_d  = ST_DATA;
               end else begin
                  htrans_d = HTRANS_SEQ;
                  haddr_d  = {base_q, next_word, 2'b00};
               end
            end
         end

         ST_DATA: begin
            if (err_q) begin
               if (HREADY) begin
                  buf_clr     = 1'b1;
                  mem_ready_d = mem_req;
                  mem_err_d   = mem_req;
                  state_d     = ST_ERR;
               end
            end else if (HRESP && !HREADY) begin
               err_d = 1'b1;
            end else if (HREADY) begin
               buf_we      = 1'b1;
               data_cnt_d  = data_cnt_q + CNT_W'(1);
               mem_ready_d = mem_req;
               state_d     = ST_DONE;
            end
         end

         ST_DONE, ST_ERR: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d  = ST_IDLE;
            htrans_d = HTRANS_IDLE;
         end
      endcase
   end

   refill_line_buffer #(
      .LINE_BITS (LINE_BITS),
      .IDX_W     (IDX_W)
   ) u_line_buf (
      .clk     (clk),
      .rst     (rst),
      .clr     (buf_clr),
      .wr_en   (buf_we),
      .wr_idx  (wr_idx),
      .wr_data (HRDATA),
      .line    (mem_data_in)
   );

   assign HTRANS    = htrans_q;
   assign HADDR     = haddr_q;
   assign HSIZE     = HSIZE_WORD;
   assign HWRITE    = 1'b0;
   assign HPROT     = HPROT_VAL;
   assign mem_ready = mem_ready_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_ahb_refill_master.sv
// Refill master bench: behavioural AHB slave with wait/error injection and a line-level reference model.
module tb_ahb_refill_master;

   localparam int LB = 128;
   localparam int NB = LB / 32;
`ifdef CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic [LB-1:0] mem_data_in;
   logic          mem_ready;
   logic          mem_err;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic [2:0]    HBURST;
   logic [2:0]    HSIZE;
   logic          HWRITE;
   logic [3:0]    HPROT;
   logic [31:0]   HRDATA;
   logic          HREADY;
   logic          HRESP;

   always #5 clk = ~clk;

   ahb_refill_master #(.LINE_BITS(LB), .HPROT_VAL(4'b0010)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_data_in (mem_data_in),
      .mem_ready   (mem_ready),
      .mem_err     (mem_err),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HBURST      (HBURST),
      .HSIZE       (HSIZE),
      .HWRITE      (HWRITE),
      .HPROT       (HPROT),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Slave memory image of the line being fetched, indexed by word within the line.
   logic [31:0] mem_word [NB];
   bit          dp_valid;
   logic [31:0] dp_addr;
   int          dp_beat;
   int          n_acc;
   int          wait_beat, waits_left, err_beat;
   bit          err_half;

   task automatic tick(output bit hr, output bit hrs, output logic [1:0] ht, output logic [31:0] ha);
      HRESP  = 1'b0;
      HREADY = 1'b1;
      HRDATA = $urandom;
      if (dp_valid) begin
         if (dp_beat == wait_beat && waits_left > 0) begin
            HREADY = 1'b0;
            waits_left--;
         end else if (dp_beat == err_beat) begin
            HRESP    = 1'b1;
            HREADY   = err_half;
            err_half = 1'b1;
         end else begin
            HRDATA = mem_word[dp_addr[3:2]];
         end
      end
      ht  = HTRANS;
      ha  = HADDR;
      hr  = HREADY;
      hrs = HRESP;
      if (HREADY) begin
         dp_valid = ht[1];
         dp_addr  = ha;
         dp_beat  = n_acc;
         if (ht[1]) n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int w = 0; w < NB; w++) mem_word[w] = $urandom;
   endtask

   task automatic run_refill(input logic [31:0] addr, input int wbeat, input int wn,
                             input int ebeat, input int drop_at, input bit chain);
      logic [31:0]   base, ha, prev_ha;
      logic [1:0]    ht, prev_ht;
      logic [LB-1:0] exp_line;
      int            start, exp_done, exp_acc;
      bit            supp, is_err, hr, hrs, prev_hr, prev_hrs;

      base       = addr & ~32'hF;
      start      = CWF ? int'(addr[3:2]) : 0;
      wait_beat  = wbeat;
      waits_left = wn;
      err_beat   = ebeat;
      err_half   = 1'b0;
      n_acc      = 0;
      is_err     = (ebeat >= 0);
      if (is_err) begin
         exp_done = ebeat + 4 + ((wbeat >= 0 && wbeat <= ebeat) ? wn : 0);
         exp_acc  = ebeat + 1;
      end else begin
         exp_done = 6 + ((wbeat >= 0) ? wn : 0);
         exp_acc  = NB;
      end
      supp = (drop_at >= 0 && drop_at < exp_done);
      exp_line = '0;
      for (int w = 0; w < NB; w++) exp_line[32*w +: 32] = mem_word[w];

      prev_hr  = 1'b1;
      prev_hrs = 1'b0;
      prev_ht  = 2'b00;
      prev_ha  = '0;
      mem_addr = addr;
      mem_req  = 1'b1;
      for (int c = 0; c <= exp_done; c++) begin
         if (c == drop_at) mem_req = 1'b0;
         if (c > 0) mem_addr = $urandom;
         if (c == 0) check_val("idle_before_req", LB'(HTRANS), LB'(2'b00));
         if (c == 1) begin
            check_val("hburst", LB'(HBURST), LB'(CWF ? 3'b010 : 3'b011));
            check_val("hsize",  LB'(HSIZE),  LB'(3'b010));
            check_val("hwrite", LB'(HWRITE), LB'(1'b0));
            check_val("hprot",  LB'(HPROT),  LB'(4'b0010));
         end
         check_val("mem_ready", LB'(mem_ready), LB'(c == exp_done && !supp));
         if (c == exp_done && !supp) begin
            check_val("mem_err", LB'(mem_err), LB'(is_err));
            check_val("line", mem_data_in, is_err ? '0 : exp_line);
         end
         if (c > 0 && !prev_hr && !prev_hrs && prev_ht[1]) begin
            check_val("hold_htrans", LB'(HTRANS), LB'(prev_ht));
            check_val("hold_haddr",  LB'(HADDR),  LB'(prev_ha));
         end
         if (prev_hrs && !prev_hr) check_val("err_cancel", LB'(HTRANS), LB'(2'b00));
         tick(hr, hrs, ht, ha);
         if (hr && ht[1] && n_acc <= NB) begin
            check_val("haddr", LB'(ha), LB'(base + 32'(((start + n_acc - 1) % NB) * 4)));
            check_val("htrans", LB'(ht), LB'((n_acc == 1) ? 2'b10 : 2'b11));
         end
         prev_hr  = hr;
         prev_hrs = hrs;
         prev_ht  = ht;
         prev_ha  = ha;
      end
      check_val("beats_issued", LB'(n_acc), LB'(exp_acc));
      check_val("ready_one_cycle", LB'(mem_ready), LB'(1'b0));
      if (!chain) begin
         mem_req = 1'b0;
         tick(hr, hrs, ht, ha);
      end
   endtask

   initial begin
      bit          hr, hrs;
      logic [1:0]  ht;
      logic [31:0] ha;
      int          wb, wn, eb, dr;

      rst        = 1'b1;
      mem_req    = 1'b0;
      mem_addr   = '0;
      HREADY     = 1'b1;
      HRESP      = 1'b0;
      HRDATA     = '0;
      dp_valid   = 1'b0;
      dp_addr    = '0;
      dp_beat    = 0;
      n_acc      = 0;
      wait_beat  = -1;
      waits_left = 0;
      err_beat   = -1;
      err_half   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_htrans", LB'(HTRANS), LB'(2'b00));
      check_val("rst_haddr",  LB'(HADDR),  LB'(32'h0));
      check_val("rst_ready",  LB'(mem_ready), LB'(1'b0));
      check_val("rst_err",    LB'(mem_err), LB'(1'b0));
      check_val("rst_line",   mem_data_in, '0);
      rst = 1'b0;
      tick(hr, hrs, ht, ha);

      for (int w = 0; w < NB; w++) mem_word[w] = CWF ? (32'h1230 + 32'(4 * w)) : (32'hA0 + 32'(w));
      run_refill(32'h0000_1238, -1, 0, -1, -1, 1'b0);

      fill_random();
      run_refill(32'h0000_1238, 1, 2, -1, -1, 1'b0);

      fill_random();
      run_refill(32'h0000_1238, -1, 0, 2, -1, 1'b0);

      // Reset asserted during cycle 3 of a burst.
      fill_random();
      wait_beat = -1;
      err_beat  = -1;
      n_acc     = 0;
      mem_addr  = 32'h300;
      mem_req   = 1'b1;
      repeat (3) tick(hr, hrs, ht, ha);
      rst = 1'b1;
      tick(hr, hrs, ht, ha);
      check_val("midrst_htrans", LB'(HTRANS), LB'(2'b00));
      check_val("midrst_haddr",  LB'(HADDR),  LB'(32'h0));
      check_val("midrst_ready",  LB'(mem_ready), LB'(1'b0));
      check_val("midrst_line",   mem_data_in, '0);
      rst      = 1'b0;
      mem_req  = 1'b0;
      dp_valid = 1'b0;
      tick(hr, hrs, ht, ha);
      fill_random();
      run_refill(32'h0000_0344, -1, 0, -1, -1, 1'b0);

      fill_random();
      run_refill(32'h0000_0100, -1, 0, -1, -1, 1'b1);
      fill_random();
      run_refill(32'h0000_0200, -1, 0, -1, -1, 1'b0);

      fill_random();
      run_refill(32'h0000_4444, -1, 0, -1, 3, 1'b0);

      for (int i = 0; i < 30; i++) begin
         fill_random();
         wb = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NB - 1));
         wn = int'($urandom_range(1, 3));
         eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
         dr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : -1;
         run_refill($urandom, wb, wn, eb, dr, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
